// File: rtl/bsram_boot_loader_pkg.sv
// bsram_boot_loader_pkg: loader FSM states and default widths
package bsram_boot_loader_pkg;
    localparam int ADDR_W = 13;
    localparam int LEN_W = 16;
    typedef enum logic [2:0] {
        ADDR_LO,
        ADDR_HI,
        LEN_LO,
        LEN_HI,
        DATA,
        SUM,
        FIN
    } loader_state_t;
endpackage

// File: rtl/bsram_boot_loader.sv
// bsram_boot_loader: framed byte stream -> BSRAM port A writes, holds CPU reset until a good load
module bsram_boot_loader #(
    parameter int ADDR_W = bsram_boot_loader_pkg::ADDR_W,
    parameter int LEN_W = bsram_boot_loader_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst
);
    import bsram_boot_loader_pkg::loader_state_t;
    import bsram_boot_loader_pkg::ADDR_LO;
    import bsram_boot_loader_pkg::ADDR_HI;
    import bsram_boot_loader_pkg::LEN_LO;
    import bsram_boot_loader_pkg::LEN_HI;
    import bsram_boot_loader_pkg::DATA;
    import bsram_boot_loader_pkg::SUM;
    import bsram_boot_loader_pkg::FIN;

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d, wdata_q, wdata_d;
    logic              we_q, we_d, done_q, done_d, err_q, err_d, acc;

    assign in_ready  = state_q != FIN;
    assign acc       = in_valid && in_ready;
    assign busy      = state_q != ADDR_LO && state_q != FIN;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cpu_rst   = !done_q || err_q;

    // ptr_q is the next write address; addr_q is the address presented with the current strobe
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        if (acc) begin
            case (state_q)
                ADDR_LO: begin
                    ptr_d   = ADDR_W'(in_data);
                    state_d = ADDR_HI;
                end
                ADDR_HI: begin
                    ptr_d   = ADDR_W'({in_data, ptr_q[7:0]});
                    state_d = LEN_LO;
                end
                LEN_LO: begin
                    cnt_d   = LEN_W'(in_data);
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    cnt_d   = LEN_W'({in_data, cnt_q[7:0]});
                    state_d = (cnt_d != '0) ? DATA : SUM;
                end
                DATA: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    cnt_d   = cnt_q - LEN_W'(1);
                    sum_d   = sum_q + in_data;
                    state_d = (cnt_q == LEN_W'(1)) ? SUM : DATA;
                end
                SUM: begin
                    err_d   = in_data != sum_q;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
                default: state_d = FIN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ADDR_LO;
            ptr_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_bsram_boot_loader.sv
// tb_bsram_boot_loader: directed frames against a behavioural BSRAM and a write log
module tb_bsram_boot_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, busy, done, err, cpu_rst;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:8191];
    logic [12:0] wa [0:255];
    logic [7:0]  wd [0:255];
    int          wc [0:255];
    int          nw = 0;
    int          cyc = 0;

    bsram_boot_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .cpu_rst(cpu_rst)
    );

    always #5 clk = ~clk;

    // BSRAM port A model plus a log of every strobe with its cycle number
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wa[nw] <= mem_addr;
            wd[nw] <= mem_wdata;
            wc[nw] <= cyc;
            nw <= nw + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 1);
        chk({tag, ".mem_we"}, 32'(mem_we), 0);
        chk({tag, ".mem_addr"}, 32'(mem_addr), 0);
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".err"}, 32'(err), 0);
        chk({tag, ".cpu_rst"}, 32'(cpu_rst), 1);
    endtask

    // gap>0 also checks busy and the single-cycle strobe between bytes
    task automatic sendv(input logic [7:0] v[$], input int gap);
        foreach (v[i]) begin
            send(v[i]);
            if (gap > 0) begin
                chk($sformatf("gap.busy%0d", i), 32'(busy), (i < v.size() - 1) ? 1 : 0);
                if (i == 4) begin
                    chk("gap.we_pulse", 32'(mem_we), 1);
                    chk("gap.we_addr", 32'(mem_addr), 32'h0200);
                    chk("gap.we_data", 32'(mem_wdata), 32'h11);
                end
                idle(1);
                if (i == 4) begin
                    chk("gap.we_low", 32'(mem_we), 0);
                    chk("gap.addr_hold", 32'(mem_addr), 32'h0200);
                end
                idle(gap - 1);
            end
        end
    endtask

    initial begin
        logic [7:0] q[$];
        int n0;
        for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
        @(negedge clk);
        do_reset();
        chk_reset_vals("rst");

        // good frame, back-to-back
        n0 = nw;
        q = '{8'h00, 8'h02, 8'h04, 8'h00, 8'h06, 8'h07, 8'h08, 8'h09, 8'h1E};
        sendv(q, 0);
        chk("t1.nwrites", 32'(nw - n0), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1.addr%0d", i), 32'(wa[n0+i]), 32'h0200 + i);
            chk($sformatf("t1.data%0d", i), 32'(wd[n0+i]), 32'h06 + i);
            chk($sformatf("t1.rd%0d", i), 32'(mem[13'h0200 + i]), 32'h06 + i);
        end
        chk("t1.consec", 32'(wc[n0+3] - wc[n0]), 3);
        chk("t1.done", 32'(done), 1);
        chk("t1.err", 32'(err), 0);
        chk("t1.cpu_rst", 32'(cpu_rst), 0);
        chk("t1.in_ready", 32'(in_ready), 0);
        chk("t1.busy", 32'(busy), 0);
        send(8'h55);
        chk("t1.fin_nowrite", 32'(nw - n0), 4);

        // bad checksum
        do_reset();
        n0 = nw;
        q = '{8'h00, 8'h02, 8'h04, 8'h00, 8'h06, 8'h07, 8'h08, 8'h09, 8'h1F};
        sendv(q, 0);
        chk("t2.nwrites", 32'(nw - n0), 4);
        chk("t2.done", 32'(done), 1);
        chk("t2.err", 32'(err), 1);
        chk("t2.cpu_rst", 32'(cpu_rst), 1);

        // address wrap, 0xFFFE masks to 0x1FFE
        do_reset();
        n0 = nw;
        q = '{8'hFE, 8'hFF, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        sendv(q, 0);
        chk("t3.nwrites", 32'(nw - n0), 3);
        chk("t3.addr0", 32'(wa[n0]), 32'h1FFE);
        chk("t3.addr1", 32'(wa[n0+1]), 32'h1FFF);
        chk("t3.addr2", 32'(wa[n0+2]), 32'h0000);
        chk("t3.rd2", 32'(mem[0]), 32'hCC);
        chk("t3.done", 32'(done), 1);
        chk("t3.err", 32'(err), 0);

        // zero length, good and bad sums
        do_reset();
        n0 = nw;
        q = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        sendv(q, 0);
        idle(1);
        chk("t4.nwrites", 32'(nw - n0), 0);
        chk("t4.done", 32'(done), 1);
        chk("t4.err", 32'(err), 0);
        do_reset();
        q = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h01};
        sendv(q, 0);
        chk("t4b.done", 32'(done), 1);
        chk("t4b.err", 32'(err), 1);

        // address masking with 3-cycle gaps
        do_reset();
        n0 = nw;
        chk("t5.busy_pre", 32'(busy), 0);
        q = '{8'h00, 8'hE2, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        sendv(q, 3);
        chk("t5.nwrites", 32'(nw - n0), 2);
        chk("t5.addr0", 32'(wa[n0]), 32'h0200);
        chk("t5.addr1", 32'(wa[n0+1]), 32'h0201);
        chk("t5.data1", 32'(wd[n0+1]), 32'h22);
        chk("t5.done", 32'(done), 1);
        chk("t5.err", 32'(err), 0);

        // reset mid-payload, then a fresh frame
        do_reset();
        q = '{8'h00, 8'h03, 8'h05, 8'h00, 8'hA1, 8'hB2};
        sendv(q, 0);
        chk("t6.busy_mid", 32'(busy), 1);
        chk("t6.we_mid", 32'(mem_we), 1);
        do_reset();
        chk_reset_vals("t6.rst");
        n0 = nw;
        q = '{8'h00, 8'h03, 8'h01, 8'h00, 8'h5A, 8'h5A};
        sendv(q, 0);
        chk("t6.nwrites", 32'(nw - n0), 1);
        chk("t6.addr", 32'(wa[n0]), 32'h0300);
        chk("t6.rd", 32'(mem[13'h0300]), 32'h5A);
        chk("t6.rd_prev", 32'(mem[13'h0301]), 32'hB2);
        chk("t6.done", 32'(done), 1);
        chk("t6.err", 32'(err), 0);
        chk("t6.cpu_rst", 32'(cpu_rst), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
